vga_timing_gen: RTL



---
 rtl/vga_pkg.sv | 38 +++
 rtl/vga_axis_cnt.sv | 51 +++++
 rtl/vga_timing_gen.sv | 129 ++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// Shared constants for the 800x600@60 VGA timing source.
// Colour-bar table exists only when VGA_TIMING_PATTERN_EN is defined.
`timescale 1ns / 1ps
package vga_pkg;

    localparam int unsigned CNT_W = 11;
    localparam int unsigned RGB_W = 12;

    localparam int unsigned H_ACTIVE = 800;
    localparam int unsigned H_FP     = 40;
    localparam int unsigned H_SYNC   = 128;
    localparam int unsigned H_BP     = 88;
    localparam int unsigned V_ACTIVE = 600;
    localparam int unsigned V_FP     = 1;
    localparam int unsigned V_SYNC   = 4;
    localparam int unsigned V_BP     = 23;

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_STOP  = H_SYNC_START + H_SYNC;
    localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_STOP  = V_SYNC_START + V_SYNC;

    localparam logic SYNC_POL = 1'b1;

`ifdef VGA_TIMING_PATTERN_EN
    localparam int unsigned BAR_W  = 100;
    localparam int unsigned N_BARS = 8;
    // Index 0 is the leftmost bar.
    localparam logic [N_BARS-1:0][RGB_W-1:0] BAR_RGB = {
        12'h000, 12'h00f, 12'hf00, 12'hf0f,
        12'h0f0, 12'h0ff, 12'hff0, 12'hfff
    };
`endif

endpackage

// File: rtl/vga_axis_cnt.sv
// One timing axis: position counter plus next-position blank and sync decode.
`timescale 1ns / 1ps
module vga_axis_cnt
    import vga_pkg::*;
#(
    parameter int unsigned TOTAL    = 1056,
    parameter int unsigned ACTIVE   = 800,
    parameter int unsigned FP       = 40,
    parameter int unsigned SYNC     = 128,
    parameter logic        POLARITY = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_i,
    output logic [CNT_W-1:0] cnt_next_o,
    output logic             wrap_o,
    output logic             blank_next_o,
    output logic             sync_next_o
);

    localparam logic [CNT_W-1:0] LAST_C       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C     = CNT_W'(ACTIVE);
    localparam logic [CNT_W-1:0] SYNC_START_C = CNT_W'(ACTIVE + FP);
    localparam logic [CNT_W-1:0] SYNC_STOP_C  = CNT_W'(ACTIVE + FP + SYNC);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // wrap_o flags the last position; the caller ANDs it with its own step.
    assign wrap_o = (cnt_q == LAST_C);

    always_comb begin
        cnt_d = cnt_q;
        if (step_i) begin
            cnt_d = wrap_o ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_next_o   = cnt_d;
    assign blank_next_o = (cnt_d >= ACTIVE_C);
    assign sync_next_o  = ((cnt_d >= SYNC_START_C) && (cnt_d < SYNC_STOP_C)) ? POLARITY : ~POLARITY;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing source: counters, syncs, blanks, start-of-frame strobe and frame counter.
// Define VGA_TIMING_PATTERN_EN to drive 8 colour bars instead of black.
`timescale 1ns / 1ps
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = vga_pkg::H_FP,
    parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
    parameter int unsigned H_BP     = vga_pkg::H_BP,
    parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = vga_pkg::V_FP,
    parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
    parameter int unsigned V_BP     = vga_pkg::V_BP,
    parameter logic        SYNC_POL = vga_pkg::SYNC_POL
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    output logic [CNT_W-1:0] vcount_o,
    output logic             vsync_o,
    output logic             vblnk_o,
    output logic [CNT_W-1:0] hcount_o,
    output logic             hsync_o,
    output logic             hblnk_o,
    output logic [RGB_W-1:0] rgb_o,
    output logic             sof_o,
    output logic [15:0]      frame_cnt_o
);

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [CNT_W-1:0] h_next, v_next;
    logic             h_wrap, v_wrap;
    logic             hblnk_d, vblnk_d, hsync_d, vsync_d;
    logic             v_step;
    logic             frame_end;
    logic [RGB_W-1:0] rgb_d;

    logic [CNT_W-1:0] hcount_q, vcount_q;
    logic             hsync_q, vsync_q, hblnk_q, vblnk_q, sof_q;
    logic [RGB_W-1:0] rgb_q;
    logic [15:0]      frame_cnt_q;

    assign v_step    = en_i & h_wrap;
    assign frame_end = en_i & h_wrap & v_wrap;

    vga_axis_cnt #(
        .TOTAL(H_TOT), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .POLARITY(SYNC_POL)
    ) u_h_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .step_i       (en_i),
        .cnt_next_o   (h_next),
        .wrap_o       (h_wrap),
        .blank_next_o (hblnk_d),
        .sync_next_o  (hsync_d)
    );

    vga_axis_cnt #(
        .TOTAL(V_TOT), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .POLARITY(SYNC_POL)
    ) u_v_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .step_i       (v_step),
        .cnt_next_o   (v_next),
        .wrap_o       (v_wrap),
        .blank_next_o (vblnk_d),
        .sync_next_o  (vsync_d)
    );

`ifdef VGA_TIMING_PATTERN_EN
    logic [2:0] bar_idx;

    // Priority comparator chain replaces h_next / BAR_W.
    always_comb begin
        bar_idx = '0;
        for (int i = 1; i < int'(N_BARS); i++) begin
            if (h_next >= CNT_W'(i * int'(BAR_W))) begin
                bar_idx = 3'(i);
            end
        end
    end

    assign rgb_d = (hblnk_d || vblnk_d) ? '0 : BAR_RGB[bar_idx];
`else
    assign rgb_d = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_q    <= '0;
            vcount_q    <= '0;
            hblnk_q     <= 1'b0;
            vblnk_q     <= 1'b0;
            hsync_q     <= ~SYNC_POL;
            vsync_q     <= ~SYNC_POL;
            rgb_q       <= '0;
            sof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            sof_q <= frame_end;
            if (en_i) begin
                hcount_q <= h_next;
                vcount_q <= v_next;
                hblnk_q  <= hblnk_d;
                vblnk_q  <= vblnk_d;
                hsync_q  <= hsync_d;
                vsync_q  <= vsync_d;
                rgb_q    <= rgb_d;
            end
            if (frame_end) begin
                frame_cnt_q <= frame_cnt_q + 16'd1;
            end
        end
    end

    assign hcount_o    = hcount_q;
    assign vcount_o    = vcount_q;
    assign hblnk_o     = hblnk_q;
    assign vblnk_o     = vblnk_q;
    assign hsync_o     = hsync_q;
    assign vsync_o     = vsync_q;
    assign rgb_o       = rgb_q;
    assign sof_o       = sof_q;
    assign frame_cnt_o = frame_cnt_q;

endmodule
